// File: rtl/cfg_pkg.sv
// cfg_serializer shared types and constants.
// Frame width, divider default, phase counter width, FSM encoding.
package cfg_pkg;

  localparam int CFG_WORD_W      = 5;
  localparam int CFG_DIV_DEFAULT = 4;
  localparam int CFG_PH_W        = 4;
  localparam int CFG_IDX_W       = 3;
  localparam int CFG_DIV_MIN     = 2;
  localparam int CFG_DIV_MAX     = 16;

  localparam logic [CFG_IDX_W-1:0] CFG_LAST_BIT =
    CFG_IDX_W'(CFG_WORD_W - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCLK_LO,
    ST_SCLK_HI,
    ST_DONE
  } cfg_state_e;

  // Frame word: amplifier 2 gain above amplifier 1 gain.
  function automatic logic [CFG_WORD_W-1:0] cfg_word(
    input logic [1:0] gain_a1,
    input logic [2:0] gain_a2
  );
    return {gain_a2, gain_a1};
  endfunction

endpackage

// File: rtl/cfg_phase_timer.sv
// Phase timer for cfg_serializer.
// Counts CLK_DIV enabled cycles, flags the last one, then wraps.
module cfg_phase_timer
  import cfg_pkg::*;
#(
  parameter int CLK_DIV = CFG_DIV_DEFAULT
) (
  input  logic i_clk,
  input  logic i_resetbAll,
  input  logic restart,
  input  logic enable,
  output logic expired
);

  localparam logic [CFG_PH_W-1:0] PH_LAST =
    CFG_PH_W'(CLK_DIV - 1);

  logic [CFG_PH_W-1:0] phase_cnt;

  assign expired = enable && (phase_cnt == PH_LAST);

  // Phase counter: cleared on restart or wrap, else counts.
  always_ff @(posedge i_clk or negedge i_resetbAll) begin
    if (!i_resetbAll) begin
      phase_cnt <= '0;
    end else if (restart || expired) begin
      phase_cnt <= '0;
    end else if (enable) begin
      phase_cnt <= phase_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/cfg_serializer.sv
// Serial configuration frame sender for the amplifier backend.
// Shifts the 5-bit gain word out LSB first on o_sclk/o_sdin.
module cfg_serializer
  import cfg_pkg::*;
#(
  parameter int CLK_DIV = CFG_DIV_DEFAULT
) (
  input  logic       i_clk,
  input  logic       i_resetbAll,
  input  logic       i_load,
  input  logic [1:0] i_gainA1,
  input  logic [2:0] i_gainA2,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_sclk,
  output logic       o_sdin
);

  if (CLK_DIV < CFG_DIV_MIN || CLK_DIV > CFG_DIV_MAX) begin : g_bad_div
    $error("cfg_serializer: CLK_DIV must be 2..16");
  end

  cfg_state_e              state;
  logic [CFG_WORD_W-1:0]   word;
  logic [CFG_IDX_W-1:0]    bit_idx;
  logic [CFG_IDX_W-1:0]    next_idx;
  logic [CFG_WORD_W-1:0]   load_word;
  logic                    accept;
  logic                    ph_en;
  logic                    ph_exp;

  assign load_word = cfg_word(i_gainA1, i_gainA2);
  assign accept    = (state == ST_IDLE) && i_load;
  assign ph_en     = (state == ST_SCLK_LO) ||
                     (state == ST_SCLK_HI);
  assign next_idx  = bit_idx + 1'b1;

  cfg_phase_timer #(
    .CLK_DIV (CLK_DIV)
  ) u_timer (
    .i_clk       (i_clk),
    .i_resetbAll (i_resetbAll),
    .restart     (accept),
    .enable      (ph_en),
    .expired     (ph_exp)
  );

  // Frame FSM with registered serial outputs.
  always_ff @(posedge i_clk or negedge i_resetbAll) begin
    if (!i_resetbAll) begin
      state   <= ST_IDLE;
      word    <= '0;
      bit_idx <= '0;
      o_busy  <= 1'b0;
      o_done  <= 1'b0;
      o_sclk  <= 1'b0;
      o_sdin  <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          o_done <= 1'b0;
          o_sclk <= 1'b0;
          if (accept) begin
            state   <= ST_SCLK_LO;
            word    <= load_word;
            bit_idx <= '0;
            o_busy  <= 1'b1;
            o_sdin  <= load_word[0];
          end else begin
            o_busy <= 1'b0;
            o_sdin <= 1'b0;
          end
        end
        ST_SCLK_LO: begin
          if (ph_exp) begin
            state  <= ST_SCLK_HI;
            o_sclk <= 1'b1;
          end
        end
        ST_SCLK_HI: begin
          if (ph_exp) begin
            o_sclk <= 1'b0;
            if (bit_idx == CFG_LAST_BIT) begin
              state  <= ST_DONE;
              o_done <= 1'b1;
              o_sdin <= 1'b0;
            end else begin
              state   <= ST_SCLK_LO;
              bit_idx <= next_idx;
              o_sdin  <= word[next_idx];
            end
          end
        end
        ST_DONE: begin
          state   <= ST_IDLE;
          bit_idx <= '0;
          o_busy  <= 1'b0;
          o_done  <= 1'b0;
          o_sclk  <= 1'b0;
          o_sdin  <= 1'b0;
        end
        default: begin
          state  <= ST_IDLE;
          o_busy <= 1'b0;
          o_done <= 1'b0;
          o_sclk <= 1'b0;
          o_sdin <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/cfg_serializer.md
CFG_SERIALIZER -- requirements
Module: cfg_serializer

Interface
REQ-001 The block SHALL use one clock and one reset: i_clk is the single clock; i_resetbAll is an asynchronous, active-low reset.
REQ-002 Parameter CLK_DIV, default 4: length of each o_sclk half-period in i_clk cycles; legal range 2..16.
REQ-003 Port i_clk, input, 1 bit: system clock; all logic on its rising edge.
REQ-004 Port i_resetbAll, input, 1 bit: asynchronous active-low reset.
REQ-005 Port i_load, input, 1 bit: request to send one configuration frame.
REQ-006 Port i_gainA1, input, 2 bits: gain code for amplifier 1.
REQ-007 Port i_gainA2, input, 3 bits: gain code for amplifier 2.
REQ-008 Port o_busy, output, 1 bit: a frame is in progress.
REQ-009 Port o_done, output, 1 bit: one-cycle pulse at frame completion.
REQ-010 Port o_sclk, output, 1 bit: serial clock to the backend, i_sclk side.
REQ-011 Port o_sdin, output, 1 bit: serial data to the backend, i_sdin side.

Function
REQ-012 Frame word SHALL be W = {i_gainA2[2:0], i_gainA1[1:0]}, 5 bits, captured in full on the accepting edge and held constant for the whole frame.
REQ-013 Bits SHALL be sent LSB first (W[0] through W[4]), so the backend's right-shifting register ends with W[0] in bit 0.
REQ-014 FSM states SHALL be IDLE, SCLK_LO, SCLK_HI and DONE.
REQ-015 In IDLE with i_load=1, the FSM SHALL go to SCLK_LO with bit index 0 and phase counter 0.
REQ-016 In IDLE, o_busy=0, o_sclk=0, o_sdin=0 and o_done=0.
REQ-017 In SCLK_LO, o_sclk=0 and o_sdin=W[bit index]; after CLK_DIV cycles the FSM SHALL go to SCLK_HI.
REQ-018 In SCLK_HI, o_sclk=1 and o_sdin SHALL stay unchanged.
REQ-019 When SCLK_HI has lasted CLK_DIV cycles, the FSM SHALL go to DONE if bit index=4; otherwise it SHALL increment bit index and return to SCLK_LO.
REQ-020 DONE SHALL last exactly one cycle with o_done=1, o_busy=1 and o_sclk=0, then return to IDLE.
REQ-021 Timing: with E0 as the accepting edge, o_sclk rising edge k (k=1..5) SHALL occur at E0+(2k-1)*CLK_DIV.
REQ-022 o_done SHALL be high from E0+10*CLK_DIV to E0+10*CLK_DIV+1.
REQ-023 o_busy SHALL be high for exactly 10*CLK_DIV+1 cycles.
REQ-024 Exactly 5 rising o_sclk edges SHALL be produced per frame; no glitches; o_sclk and o_sdin SHALL be driven from registers.
REQ-025 i_load while o_busy=1, including the DONE cycle, SHALL be ignored and SHALL NOT be queued.
REQ-026 i_load held high continuously SHALL start a new frame on the first IDLE cycle, giving back-to-back frames with one IDLE cycle between them.
REQ-027 Input changes during a frame SHALL NOT affect the frame in progress.
REQ-028 The phase counter SHALL be 4 bits and count 0..CLK_DIV-1, then wrap to 0 at each phase change.
REQ-029 The bit index SHALL be 3 bits and never exceed 4.

Reset
REQ-030 When i_resetbAll=0, the FSM SHALL go to IDLE immediately, asynchronously, and every output SHALL be 0 (o_busy, o_done, o_sclk, o_sdin).
REQ-031 During reset, the captured word, bit index and phase counter SHALL be 0.
REQ-032 A reset mid-frame SHALL abandon the frame; a partial frame SHALL NOT resume after reset.
REQ-033 After i_resetbAll rises, the first i_load SHALL be accepted on the first rising i_clk edge at which it is high.

Structure
REQ-034 The shared package cfg_pkg SHALL hold the state encoding enum, CFG_WORD_W=5, CFG_DIV_DEFAULT=4 and the 4-bit phase counter width.
REQ-035 The CLK_DIV phase counter SHALL be a single sub-module, cfg_phase_timer (inputs: restart, enable; output: expired after CLK_DIV cycles).
REQ-036 An elaboration-time check SHALL reject CLK_DIV values outside 2..16.

Verification
REQ-037 Scenario 1: CLK_DIV=4, gainA1=2'b10, gainA2=3'b101, one-cycle i_load -> o_sdin samples at o_sclk rising edges are 0,1,1,0,1; rising edges at E0+4/12/20/28/36; o_done at E0+40; backend model ends with o_gainA1=2'b10 and o_gainA2=3'b101.
REQ-038 Scenario 2: i_load pulses at E0+5 and E0+40 (DONE cycle) -> both ignored; only 5 o_sclk edges; o_busy low at E0+41.
REQ-039 Scenario 3: i_load held high for 100 cycles with CLK_DIV=2 -> frames of 21 busy cycles separated by exactly 1 IDLE cycle; 5 edges per frame.
REQ-040 Scenario 4: i_resetbAll low at E0+14 (mid bit 1) -> all outputs 0 with no clock edge needed; after release, a new i_load with word 5'b11111 -> five 1 bits, correct timing.
REQ-041 Scenario 5: inputs change every cycle during a frame loaded with 5'b00001 -> serialized bits are 1,0,0,0,0.
REQ-042 Scenario 6: CLK_DIV=16 and CLK_DIV=2 -> o_busy lengths of 161 and 21 cycles respectively; o_sclk high and low widths of exactly CLK_DIV cycles.
